sequenciador_de_pc: RTL
=======================

Name: sequenciador_de_pc

Overview:
Multi-cycle control sequencer for the ReduxV program counter. Steps each instruction through INIT/FETCH/DECODE/EXEC/HALT and drives next_pc into contador_de_programa. contador_de_programa has no reset or enable, so this block holds the PC by returning curr_pc and forces the reset vector. It also emits per-phase enables for the IR, decoder and ALU stages, plus a retired-instruction counter.

Parameters:
PC_W, 8, PC width in bits
PC_INC, 4, sequential increment
RESET_VEC, 8'h00, PC value loaded after reset
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
curr_pc  in  PC_W  current PC from contador_de_programa
next_pc  out  PC_W  value PC loads on next rising edge
stall  in  1  hold current phase (memory or operand not ready)
halt  in  1  decoded HALT instruction, sampled in EXEC
jump  in  1  unconditional jump, sampled in EXEC
jump_target  in  PC_W  jump destination
branch_taken  in  1  conditional branch resolved taken, sampled in EXEC
branch_target  in  PC_W  branch destination
fetch_en  out  1  IR load enable, high in FETCH
decode_en  out  1  decoder/register-read enable, high in DECODE
exec_en  out  1  ALU/writeback enable, high in EXEC
halted  out  1  high in HALT
state  out  3  current state encoding, for debug
retired  out  CNT_W  count of completed instructions

Behaviour:
- Encodings: INIT=0, FETCH=1, DECODE=2, EXEC=3, HALT=4. Unused codes go to INIT.
- Reset: rst high asynchronously forces state=INIT, retired=0, and clears epc/in_irq when present.
  - While rst is high, all enables and halted are 0 and next_pc=RESET_VEC.
  - Every clock edge during reset therefore loads RESET_VEC into the PC.
- INIT: next_pc=RESET_VEC. Goes to FETCH after exactly 1 cycle, ignoring stall, so the PC equals RESET_VEC in the first FETCH.
- FETCH: fetch_en=1, next_pc=curr_pc. Goes to DECODE; stall=1 holds FETCH.
- DECODE: decode_en=1, next_pc=curr_pc. Goes to EXEC; stall=1 holds DECODE.
- EXEC: exec_en=1. Outcome is selected by fixed priority:
  1. stall: next_pc=curr_pc, remain in EXEC.
  2. halt: next_pc=curr_pc, go to HALT, retired increments.
  3. jump: next_pc=jump_target.
  4. branch_taken: next_pc=branch_target.
  5. otherwise: next_pc=curr_pc+PC_INC, truncated to PC_W (8'hFC+4 wraps to 8'h00).
  - Outcomes 3-5 go to FETCH and increment retired.
  - If jump and branch_taken are both high, jump wins.
- HALT: halted=1, next_pc=curr_pc. Exit only via rst (or via irq when the optional feature is built in).
- retired saturates at all-ones and never wraps.
- Instruction latency: 3 cycles minimum (FETCH, DECODE, EXEC), plus 1 per stall cycle.
- next_pc is combinational from state, rst and inputs. All other outputs are registered or decoded from the state register.

Optional Feature:
- Macro: REDUXV_IRQ_EN.
- When defined, adds ports:
  - irq in 1: level interrupt request.
  - iret in 1: return-from-interrupt, sampled in EXEC.
  - epc out PC_W: saved return PC.
  - in_irq out 1: handler active.
- EXEC, non-stall, non-halt completion with irq=1 and in_irq=0:
  - epc <= the PC the priority mux would otherwise select.
  - next_pc = IRQ_VEC (package constant 8'hF0).
  - in_irq <= 1.
- EXEC with iret=1 and in_irq=1: next_pc = epc, in_irq <= 0. iret outranks jump and branch. irq is ignored in this cycle.
- HALT with irq=1 and in_irq=0: epc <= curr_pc+PC_INC, next_pc = IRQ_VEC, in_irq <= 1, go to FETCH.
- Nested interrupts are not taken.
- When undefined: these ports and registers do not exist, and behaviour is exactly as above.

Decomposition:
- Package reduxv_pkg holds:
  - state encoding constants.
  - PC_W_DEF=8, PC_INC_DEF=4.
  - RESET_VEC and IRQ_VEC.
- Sub-module seletor_prox_pc: purely combinational priority mux (stall/halt/iret/jump/branch/increment) producing the EXEC-phase next_pc. The top level holds the FSM, retired counter and IRQ registers.

Test Plan:
- Reset then release, stall=0 -> INIT for 1 cycle, then PC=0 and state=FETCH. Over 3 instructions PC steps 0, 4, 8, each value held 3 cycles. retired=3.
- PC preset 8'hFC, plain EXEC -> next_pc=8'h00 (wrap).
- EXEC with jump=1, jump_target=8'h40, and branch_taken=1, branch_target=8'h20 -> PC=8'h40. The next instruction with branch only (target 8'h20) -> PC=8'h20.
- stall held 2 cycles in DECODE, then 1 cycle in EXEC -> PC unchanged throughout, instruction takes 6 cycles, retired increments once.
- halt=1 in EXEC at PC=8'h10 -> halted=1, PC stays 8'h10 for 20 cycles. Async rst pulse between clock edges -> state=INIT immediately, next_pc=8'h00.
- REDUXV_IRQ_EN: irq=1 in EXEC at PC=8'h08 -> PC=8'hF0, epc=8'h0C, in_irq=1. A later iret -> PC=8'h0C, in_irq=0.

Source files
------------

// File: rtl/reduxv_pkg.sv
// Shared constants for the ReduxV PC sequencer: state codes, widths, vectors.
package reduxv_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    localparam int PC_W_DEF   = 8;
    localparam int PC_INC_DEF = 4;

    localparam logic [7:0] RESET_VEC = 8'h00;
    localparam logic [7:0] IRQ_VEC   = 8'hF0;

endpackage

// File: rtl/seletor_prox_pc.sv
// EXEC-phase next-PC priority mux for the ReduxV sequencer.
// Order: stall, halt, iret, jump, branch, sequential increment.
module seletor_prox_pc
    import reduxv_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int PC_INC = PC_INC_DEF
) (
    input  logic [PC_W-1:0] curr_pc_i,
    input  logic            stall_i,
    input  logic            halt_i,
    input  logic            iret_i,
    input  logic [PC_W-1:0] epc_i,
    input  logic            jump_i,
    input  logic [PC_W-1:0] jump_target_i,
    input  logic            branch_taken_i,
    input  logic [PC_W-1:0] branch_target_i,
    output logic [PC_W-1:0] next_pc_o
);

    logic [PC_W-1:0] pc_inc;

    // Wraps naturally at PC_W bits.
    assign pc_inc = curr_pc_i + PC_W'(PC_INC);

    always_comb begin
        next_pc_o = pc_inc;
        priority case (1'b1)
            stall_i:        next_pc_o = curr_pc_i;
            halt_i:         next_pc_o = curr_pc_i;
            iret_i:         next_pc_o = epc_i;
            jump_i:         next_pc_o = jump_target_i;
            branch_taken_i: next_pc_o = branch_target_i;
            default:        next_pc_o = pc_inc;
        endcase
    end

endmodule

// File: rtl/sequenciador_de_pc.sv
// ReduxV multi-cycle PC sequencer: INIT/FETCH/DECODE/EXEC/HALT FSM.
// Optional interrupt entry/return built in with `define REDUXV_IRQ_EN.
module sequenciador_de_pc
    import reduxv_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter int              PC_INC    = PC_INC_DEF,
    parameter logic [PC_W-1:0] RESET_VEC = reduxv_pkg::RESET_VEC,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  curr_pc,
    output logic [PC_W-1:0]  next_pc,
    input  logic             stall,
    input  logic             halt,
    input  logic             jump,
    input  logic [PC_W-1:0]  jump_target,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
`ifdef REDUXV_IRQ_EN
    input  logic             irq,
    input  logic             iret,
    output logic [PC_W-1:0]  epc,
    output logic             in_irq,
`endif
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [PC_W-1:0] exec_pc;
    logic            complete;
    logic            irq_exec;
    logic            irq_halt;
    logic            iret_mux;
    logic [PC_W-1:0] epc_mux;

    assign complete = (state_q == ST_EXEC) && !stall;

`ifdef REDUXV_IRQ_EN
    logic [PC_W-1:0] epc_q, epc_d;
    logic            in_irq_q, in_irq_d;
    logic            iret_take;

    assign iret_mux  = iret && in_irq_q;
    assign epc_mux   = epc_q;
    assign iret_take = complete && !halt && iret_mux;
    assign irq_exec  = complete && !halt && irq && !in_irq_q;
    assign irq_halt  = (state_q == ST_HALT) && irq && !in_irq_q;

    always_comb begin
        epc_d    = epc_q;
        in_irq_d = in_irq_q;
        if (irq_exec) begin
            epc_d    = exec_pc;
            in_irq_d = 1'b1;
        end else if (irq_halt) begin
            epc_d    = curr_pc + PC_W'(PC_INC);
            in_irq_d = 1'b1;
        end else if (iret_take) begin
            in_irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_q    <= '0;
            in_irq_q <= 1'b0;
        end else begin
            epc_q    <= epc_d;
            in_irq_q <= in_irq_d;
        end
    end

    assign epc    = epc_q;
    assign in_irq = in_irq_q;
`else
    assign iret_mux = 1'b0;
    assign epc_mux  = '0;
    assign irq_exec = 1'b0;
    assign irq_halt = 1'b0;
`endif

    seletor_prox_pc #(
        .PC_W   (PC_W),
        .PC_INC (PC_INC)
    ) u_sel (
        .curr_pc_i       (curr_pc),
        .stall_i         (stall),
        .halt_i          (halt),
        .iret_i          (iret_mux),
        .epc_i           (epc_mux),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .next_pc_o       (exec_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_INIT;
        unique case (state_q)
            ST_INIT:   state_d = ST_FETCH;
            ST_FETCH:  state_d = stall ? ST_FETCH : ST_DECODE;
            ST_DECODE: state_d = stall ? ST_DECODE : ST_EXEC;
            ST_EXEC: begin
                if (stall)     state_d = ST_EXEC;
                else if (halt) state_d = ST_HALT;
                else           state_d = ST_FETCH;
            end
            ST_HALT:   state_d = irq_halt ? ST_FETCH : ST_HALT;
            default:   state_d = ST_INIT;
        endcase
    end

    // PC has no reset or enable of its own, so hold means feeding curr_pc back.
    always_comb begin
        next_pc   = curr_pc;
        fetch_en  = 1'b0;
        decode_en = 1'b0;
        exec_en   = 1'b0;
        halted    = 1'b0;
        if (rst) begin
            next_pc = RESET_VEC;
        end else begin
            unique case (state_q)
                ST_INIT: next_pc = RESET_VEC;
                ST_FETCH: begin
                    fetch_en = 1'b1;
                    next_pc  = curr_pc;
                end
                ST_DECODE: begin
                    decode_en = 1'b1;
                    next_pc   = curr_pc;
                end
                ST_EXEC: begin
                    exec_en = 1'b1;
                    next_pc = irq_exec ? PC_W'(IRQ_VEC) : exec_pc;
                end
                ST_HALT: begin
                    halted  = 1'b1;
                    next_pc = irq_halt ? PC_W'(IRQ_VEC) : curr_pc;
                end
                default: next_pc = RESET_VEC;
            endcase
        end
    end

    always_comb begin
        retired_d = retired_q;
        if (complete && (retired_q != {CNT_W{1'b1}})) begin
            retired_d = retired_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule
